perceptron_seq: RTL and testbench

//  Sequencer for the single-layer perceptron datapath. Owns the weight/bias registers and time-shares one signed MAC across NUM_INPUTS inputs.

---
 rtl/perceptron_pkg.sv | 32 +++
 rtl/perceptron_mac.sv | 20 ++
 rtl/perceptron_seq.sv | 188 ++++++++++++++++++
 tb/tb_perceptron_seq.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_pkg.sv
// Shared state encoding and width/saturation helpers for the perceptron sequencer.
// PERCEPTRON_TRAIN_EN adds the UPDATE state used by online training.
package perceptron_pkg;

`ifdef PERCEPTRON_TRAIN_EN
   typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_OUT, ST_UPDATE} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_OUT} state_t;
`endif

   function automatic int addr_width(input int num_inputs);
      return $clog2(num_inputs + 1);
   endfunction

   function automatic int acc_width(input int num_inputs, input int data_w, input int weight_w);
      return data_w + weight_w + $clog2(num_inputs + 1);
   endfunction

   function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v, input int width);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (width - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (width - 1));
      if (v > hi)
         return hi;
      else if (v < lo)
         return lo;
      else
         return v;
   endfunction

endpackage

// File: rtl/perceptron_mac.sv
// Combinational signed multiply-accumulate: acc_out = acc_in + x*w, product sign-extended.
module perceptron_mac #(
   parameter int DATA_W   = 8,
   parameter int WEIGHT_W = 8,
   parameter int ACC_W    = 19
) (
   input  logic signed [DATA_W-1:0]   x,
   input  logic signed [WEIGHT_W-1:0] w,
   input  logic signed [ACC_W-1:0]    acc_in,
   output logic signed [ACC_W-1:0]    acc_out
);

   localparam int PW = DATA_W + WEIGHT_W;

   logic signed [PW-1:0] prod;

   assign prod    = x * w;
   assign acc_out = acc_in + {{(ACC_W - PW){prod[PW-1]}}, prod};

endmodule

// File: rtl/perceptron_seq.sv
// Perceptron sequencer: one shared MAC over NUM_INPUTS cycles, result held until out_ready.
// PERCEPTRON_TRAIN_EN adds in_train/in_target and a NUM_INPUTS+1 cycle weight update.
module perceptron_seq
   import perceptron_pkg::*;
#(
   parameter int NUM_INPUTS = 4,
   parameter int DATA_W     = 8,
   parameter int WEIGHT_W   = 8,
   parameter int LR_SHIFT   = 0,
   localparam int ACC_W     = acc_width(NUM_INPUTS, DATA_W, WEIGHT_W),
   localparam int AW        = addr_width(NUM_INPUTS)
) (
   input  logic                           clk,
   input  logic                           r_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [NUM_INPUTS*DATA_W-1:0]   in_data,
   input  logic                           w_wr_en,
   input  logic [AW-1:0]                  w_wr_addr,
   input  logic signed [WEIGHT_W-1:0]     w_wr_data,
   output logic                           busy,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           out_y,
`ifdef PERCEPTRON_TRAIN_EN
   input  logic                           in_train,
   input  logic                           in_target,
`endif
   output logic signed [ACC_W-1:0]        out_acc
);

   localparam int NW = NUM_INPUTS + 1;
   localparam logic [AW-1:0] LAST_X    = AW'(NUM_INPUTS - 1);
   localparam logic [AW-1:0] BIAS_ADDR = AW'(NUM_INPUTS);

   state_t state, state_nxt;

   logic signed [WEIGHT_W-1:0] w [NW];
   logic signed [DATA_W-1:0]   x [NUM_INPUTS];
   logic [AW-1:0]              idx;
   logic signed [ACC_W-1:0]    acc;

   logic                       accept, mac_last, out_fire;
   logic signed [DATA_W-1:0]   x_sel, mac_x;
   logic signed [WEIGHT_W-1:0] w_sel, mac_w, bias_init;
   logic signed [ACC_W-1:0]    mac_acc, mac_sum;

`ifdef PERCEPTRON_TRAIN_EN
   logic                       train_q, target_q;
   logic signed [WEIGHT_W-1:0] upd_w;
`endif

   always_comb begin
      x_sel = '0;
      w_sel = '0;
      for (int i = 0; i < NUM_INPUTS; i++)
         if (idx == AW'(i)) x_sel = x[i];
      for (int i = 0; i < NW; i++)
         if (idx == AW'(i)) w_sel = w[i];
   end

   // In UPDATE the MAC computes e*x (e = +/-1) from zero; the bias slot uses x = 1.
   always_comb begin
      mac_x   = x_sel;
      mac_w   = w_sel;
      mac_acc = acc;
`ifdef PERCEPTRON_TRAIN_EN
      if (state == ST_UPDATE) begin
         mac_x   = (idx == BIAS_ADDR) ? DATA_W'(1) : x_sel;
         mac_w   = target_q ? WEIGHT_W'(1) : {WEIGHT_W{1'b1}};
         mac_acc = '0;
      end
`endif
   end

   perceptron_mac #(
      .DATA_W   (DATA_W),
      .WEIGHT_W (WEIGHT_W),
      .ACC_W    (ACC_W)
   ) u_mac (
      .x       (mac_x),
      .w       (mac_w),
      .acc_in  (mac_acc),
      .acc_out (mac_sum)
   );

`ifdef PERCEPTRON_TRAIN_EN
   assign upd_w = WEIGHT_W'(sat_signed(32'(w_sel) + 32'(mac_sum >>> LR_SHIFT), WEIGHT_W));
`endif

   // A bias write on the accept cycle must be seen by the vector being accepted.
   assign bias_init = (w_wr_en && w_wr_addr == BIAS_ADDR) ? w_wr_data : w[NUM_INPUTS];

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      busy      = 1'b1;
      accept    = 1'b0;
      mac_last  = 1'b0;
      out_fire  = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               accept    = 1'b1;
               state_nxt = ST_MAC;
            end
         end
         ST_MAC: begin
            if (idx == LAST_X) begin
               mac_last  = 1'b1;
               state_nxt = ST_OUT;
            end
         end
         ST_OUT: begin
            if (out_ready) begin
               out_fire  = 1'b1;
               state_nxt = ST_IDLE;
`ifdef PERCEPTRON_TRAIN_EN
               if (train_q && (out_y != target_q)) state_nxt = ST_UPDATE;
`endif
            end
         end
`ifdef PERCEPTRON_TRAIN_EN
         ST_UPDATE: begin
            if (idx == BIAS_ADDR) state_nxt = ST_IDLE;
         end
`endif
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge r_n) begin
      if (!r_n) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk or negedge r_n) begin
      if (!r_n) begin
         for (int i = 0; i < NW; i++) w[i] <= '0;
         for (int i = 0; i < NUM_INPUTS; i++) x[i] <= '0;
         idx       <= '0;
         acc       <= '0;
         out_valid <= 1'b0;
         out_y     <= 1'b0;
         out_acc   <= '0;
`ifdef PERCEPTRON_TRAIN_EN
         train_q   <= 1'b0;
         target_q  <= 1'b0;
`endif
      end else begin
         if (state == ST_IDLE && w_wr_en)
            for (int i = 0; i < NW; i++)
               if (w_wr_addr == AW'(i)) w[i] <= w_wr_data;
         if (accept) begin
            for (int i = 0; i < NUM_INPUTS; i++) x[i] <= in_data[i*DATA_W +: DATA_W];
            acc <= {{(ACC_W - WEIGHT_W){bias_init[WEIGHT_W-1]}}, bias_init};
            idx <= '0;
`ifdef PERCEPTRON_TRAIN_EN
            train_q  <= in_train;
            target_q <= in_target;
`endif
         end
         if (state == ST_MAC) begin
            acc <= mac_sum;
            idx <= idx + AW'(1);
         end
         if (mac_last) begin
            out_acc   <= mac_sum;
            out_y     <= ~mac_sum[ACC_W-1];
            out_valid <= 1'b1;
         end
         if (out_fire) begin
            out_valid <= 1'b0;
            idx       <= '0;
         end
`ifdef PERCEPTRON_TRAIN_EN
         if (state == ST_UPDATE) begin
            for (int i = 0; i < NW; i++)
               if (idx == AW'(i)) w[i] <= upd_w;
            idx <= idx + AW'(1);
         end
`endif
      end
   end

endmodule

// File: tb/tb_perceptron_seq.sv
// Directed bench for perceptron_seq with hand-computed sums (default parameters, ACC_W = 19).
module tb_perceptron_seq;

   logic               clk = 1'b0;
   logic               r_n;
   logic               in_valid;
   logic               in_ready;
   logic [31:0]        in_data;
   logic               w_wr_en;
   logic [2:0]         w_wr_addr;
   logic signed [7:0]  w_wr_data;
   logic               busy;
   logic               out_valid;
   logic               out_ready;
   logic               out_y;
   logic               in_train;
   logic               in_target;
   logic signed [18:0] out_acc;

   int checks   = 0;
   int failures = 0;

   perceptron_seq dut (
      .clk       (clk),
      .r_n       (r_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .w_wr_en   (w_wr_en),
      .w_wr_addr (w_wr_addr),
      .w_wr_data (w_wr_data),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
`ifdef PERCEPTRON_TRAIN_EN
      .in_train  (in_train),
      .in_target (in_target),
`endif
      .out_acc   (out_acc)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic write_w(input int addr, input int data);
      w_wr_en   = 1'b1;
      w_wr_addr = 3'(addr);
      w_wr_data = 8'(data);
      @(posedge clk);
      @(negedge clk);
      w_wr_en = 1'b0;
   endtask

   // Called at a negedge while idle; returns at the negedge after the accept edge.
   task automatic apply_vec(input int x0, input int x1, input int x2, input int x3,
                            input logic trn, input logic tgt);
      in_data   = {8'(x3), 8'(x2), 8'(x1), 8'(x0)};
      in_train  = trn;
      in_target = tgt;
      in_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      w_wr_en  = 1'b0;
   endtask

   // Edges after the accept edge until out_valid is seen (bounded).
   task automatic wait_out(output int lat);
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
   endtask

   // Assumes out_ready=1: handshake edge, then count cycles still busy (UPDATE).
   task automatic finish_vec(output logic rdy_after, output int upd);
      @(posedge clk);
      @(negedge clk);
      rdy_after = in_ready;
      upd = 0;
      while (busy && upd < 30) begin
         upd++;
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic run_vec(input string tag, input int x0, input int x1, input int x2, input int x3,
                          input logic trn, input logic tgt,
                          input int exp_acc, input int exp_y, input int exp_upd);
      int   lat;
      int   upd;
      logic rdy;
      apply_vec(x0, x1, x2, x3, trn, tgt);
      wait_out(lat);
      check({tag, "_lat"}, lat, 4);
      check({tag, "_acc"}, out_acc, exp_acc);
      check({tag, "_y"}, out_y, exp_y);
      finish_vec(rdy, upd);
      check({tag, "_upd"}, upd, exp_upd);
   endtask

   initial begin
      int   lat;
      int   stable;
      int   upd;
      logic rdy;

      r_n       = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      w_wr_en   = 1'b0;
      w_wr_addr = '0;
      w_wr_data = '0;
      out_ready = 1'b1;
      in_train  = 1'b0;
      in_target = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_y", out_y, 0);
      check("rst_out_acc", out_acc, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 1);
      r_n = 1'b1;
      @(negedge clk);

      // Basic: 1+2+3+4 - 5 = 5
      write_w(0, 1); write_w(1, 2); write_w(2, 3); write_w(3, 4); write_w(4, -5);
      apply_vec(1, 1, 1, 1, 1'b0, 1'b0);
      check("basic_busy", busy, 1);
      check("basic_in_ready_busy", in_ready, 0);
      wait_out(lat);
      check("basic_lat", lat, 4);
      check("basic_acc", out_acc, 5);
      check("basic_y", out_y, 1);
      finish_vec(rdy, upd);
      check("basic_in_ready_after", rdy, 1);
      check("basic_valid_cleared", out_valid, 0);
      check("basic_upd", upd, 0);

      // Extremes: 4*127*(-128) = -65024; 4*(-128)*(-128) + 127 = 65663
      write_w(0, -128); write_w(1, -128); write_w(2, -128); write_w(3, -128); write_w(4, 0);
      run_vec("ext_neg", 127, 127, 127, 127, 1'b0, 1'b0, -65024, 0, 0);
      write_w(4, 127);
      run_vec("ext_pos", -128, -128, -128, -128, 1'b0, 1'b0, 65663, 1, 0);

      // Backpressure: A = -5 - (1+2+3+4) = -15; pending B = -5 + 4*3 = 7
      write_w(0, 1); write_w(1, 2); write_w(2, 3); write_w(3, 4); write_w(4, -5);
      out_ready = 1'b0;
      apply_vec(-1, -1, -1, -1, 1'b0, 1'b0);
      wait_out(lat);
      check("bp_lat", lat, 4);
      in_data  = {8'sd3, 8'sd0, 8'sd0, 8'sd0};
      in_valid = 1'b1;
      stable = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (out_valid === 1'b1 && out_acc === -19'sd15 && out_y === 1'b0 && in_ready === 1'b0 && busy === 1'b1)
            stable++;
      end
      check("bp_stable_cycles", stable, 10);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_hs_valid_cleared", out_valid, 0);
      check("bp_hs_in_ready", in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("bp_b_accepted", busy, 1);
      wait_out(lat);
      check("bp_b_lat", lat, 4);
      check("bp_b_acc", out_acc, 7);
      check("bp_b_y", out_y, 1);
      finish_vec(rdy, upd);

      // Write during MAC is dropped: sum = -5 + 1
      apply_vec(1, 0, 0, 0, 1'b0, 1'b0);
      write_w(0, 9);
      wait_out(lat);
      check("mac_wr_acc", out_acc, -4);
      finish_vec(rdy, upd);
      // Out-of-range addresses are dropped; weights unchanged
      write_w(5, 100);
      write_w(7, 100);
      run_vec("oob_wr", 1, 1, 1, 1, 1'b0, 1'b0, 5, 1, 0);
      // Write on the accept cycle is used: w0 = 9 -> -5 + 9; bias = 10 with x = 0
      w_wr_en = 1'b1; w_wr_addr = 3'd0; w_wr_data = 8'sd9;
      run_vec("acc_wr_w0", 1, 0, 0, 0, 1'b0, 1'b0, 4, 1, 0);
      w_wr_en = 1'b1; w_wr_addr = 3'd4; w_wr_data = 8'sd10;
      run_vec("acc_wr_bias", 0, 0, 0, 0, 1'b0, 1'b0, 10, 1, 0);

      // Reset during the second MAC cycle
      apply_vec(1, 1, 1, 1, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      r_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_out_acc", out_acc, 0);
      @(negedge clk);
      r_n = 1'b1;
      @(negedge clk);
      run_vec("post_rst", 1, 1, 1, 1, 1'b0, 1'b0, 0, 1, 0);

`ifdef PERCEPTRON_TRAIN_EN
      // Train: zero weights, x = 2, target 0 -> y = 1, w = -2 each, bias = -1
      run_vec("train1", 2, 2, 2, 2, 1'b1, 1'b0, 0, 1, 5);
      run_vec("train2", 2, 2, 2, 2, 1'b1, 1'b0, -17, 0, 0);
      run_vec("train_x1", 1, 0, 0, 0, 1'b0, 1'b1, -3, 0, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
